// File: rtl/alu_pkg.sv
// Shared opcode encoding and width constants for the 4-bit ALU.
package alu_pkg;

  localparam int OPW  = 4;
  localparam int RESW = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_LSL = 3'b100,
    OP_LSR = 3'b101,
    OP_AND = 3'b110,
    OP_OR  = 3'b111
  } op_e;

endpackage

// File: rtl/alu_4bit_shifter.sv
// Logical shifter for the ALU: LSL widens into the full 8-bit result,
// LSR stays within the 4-bit operand. Carry reports bits lost or spilled.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic            shift_right,
  output logic [RESW-1:0] res,
  output logic            carry
);

  logic [RESW-1:0] lsl_res;
  logic [OPW-1:0]  lsr_res;
  logic [OPW-1:0]  lsr_back;

  // Shift amounts past the operand width naturally produce zero.
  always_comb begin
    lsl_res  = {{(RESW-OPW){1'b0}}, a} << b;
    lsr_res  = a >> b;
    // Shifting the LSR result back exposes exactly the bits that fell off.
    lsr_back = lsr_res << b;
    if (shift_right) begin
      res   = {{(RESW-OPW){1'b0}}, lsr_res};
      carry = |(a ^ lsr_back);
    end else begin
      res   = lsl_res;
      carry = |lsl_res[RESW-1:OPW];
    end
  end

endmodule

// File: rtl/alu_4bit.sv
// Registered 4-bit ALU: one-cycle latency, result and flags held between
// requests, out_valid pulses once per captured request.
module alu_4bit
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic [2:0]      sel,
  output logic [RESW-1:0] out,
  output logic            cflag,
  output logic            zflag,
  output logic            out_valid
);

  logic [RESW-1:0] out_d, out_q;
  logic            cflag_d, cflag_q;
  logic            zflag_d, zflag_q;
  logic            out_valid_d, out_valid_q;

  logic [RESW-1:0] res;
  logic            res_c;
  logic [RESW-1:0] sh_res;
  logic            sh_c;
  logic [OPW:0]    sum;
  logic [OPW-1:0]  diff;
  logic [RESW-1:0] prod;
  logic [OPW-1:0]  quot;
  logic [OPW-1:0]  rem;

  alu_shifter u_shifter (
    .a           (a),
    .b           (b),
    .shift_right (sel[0]),
    .res         (sh_res),
    .carry       (sh_c)
  );

  // Opcode datapath: all operations evaluated, the selected one muxed out.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = a - b;
    prod  = {{(RESW-OPW){1'b0}}, a} * {{(RESW-OPW){1'b0}}, b};
    quot  = a / b;
    rem   = a % b;
    res   = '0;
    res_c = 1'b0;
    case (op_e'(sel))
      OP_ADD: begin
        res   = {{(RESW-OPW-1){1'b0}}, sum};
        res_c = sum[OPW];
      end
      OP_SUB: begin
        res   = {{(RESW-OPW){1'b0}}, diff};
        res_c = (a < b);
      end
      OP_MUL: begin
        res   = prod;
        res_c = |prod[RESW-1:OPW];
      end
      OP_DIV: begin
        // Divide-by-zero reports all-ones quotient and passes a through as remainder.
        if (b == '0) begin
          res   = {a, {OPW{1'b1}}};
          res_c = 1'b1;
        end else begin
          res   = {rem, quot};
          res_c = 1'b0;
        end
      end
      OP_LSL, OP_LSR: begin
        res   = sh_res;
        res_c = sh_c;
      end
      OP_AND: res = {{(RESW-OPW){1'b0}}, a & b};
      OP_OR:  res = {{(RESW-OPW){1'b0}}, a | b};
      default: begin
        res   = '0;
        res_c = 1'b0;
      end
    endcase
  end

  // Capture on a valid request, otherwise hold the previous result.
  always_comb begin
    out_d       = out_q;
    cflag_d     = cflag_q;
    zflag_d     = zflag_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_d       = res;
      cflag_d     = res_c;
      zflag_d     = (res == '0);
      out_valid_d = 1'b1;
    end
  end

  // Output register stage; reset wins over a same-cycle request.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      cflag_q     <= 1'b0;
      zflag_q     <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      cflag_q     <= cflag_d;
      zflag_q     <= zflag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign cflag     = cflag_q;
  assign zflag     = zflag_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit: directed plan vectors plus randomized
// traffic compared against an arithmetic reference model.
module tb_alu_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a, b;
  logic [2:0] sel;
  logic [7:0] out;
  logic       cflag, zflag, out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_out;
  logic       m_c, m_z, m_v;

  alu_4bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out       (out),
    .cflag     (cflag),
    .zflag     (zflag),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference computed with plain integer arithmetic.
  function automatic void ref_alu(input int ia, input int ib, input int isel,
                                  output logic [7:0] r, output logic c);
    int res;
    int lim;
    res = 0;
    c   = 1'b0;
    case (isel)
      0: begin res = ia + ib; c = (res > 15); end
      1: begin res = (ia - ib + 16) % 16; c = (ia < ib); end
      2: begin res = ia * ib; c = (res > 15); end
      3: begin
        if (ib == 0) begin res = ia * 16 + 15; c = 1'b1; end
        else res = (ia % ib) * 16 + ia / ib;
      end
      4: begin res = (ia * (1 << ib)) % 256; c = (res >= 16); end
      5: begin
        lim = (ib < 4) ? ib : 4;
        res = ia / (1 << ib);
        c   = ((ia % (1 << lim)) != 0);
      end
      6: res = ia & ib;
      default: res = ia | ib;
    endcase
    r = res[7:0];
  endfunction

  task automatic cycle(input bit r, input bit v, input int ia, input int ib, input int is);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = ia[3:0];
    b        = ib[3:0];
    sel      = is[2:0];
    @(posedge clk);
    #1;
    if (r) begin
      m_out = 8'h00; m_c = 1'b0; m_z = 1'b1; m_v = 1'b0;
    end else if (v) begin
      ref_alu(ia, ib, is, m_out, m_c);
      m_z = (m_out == 8'h00);
      m_v = 1'b1;
    end else begin
      m_v = 1'b0;
    end
    chk($sformatf("out a=%0d b=%0d sel=%0d", ia, ib, is), {24'h0, out}, {24'h0, m_out});
    chk($sformatf("cflag a=%0d b=%0d sel=%0d", ia, ib, is), {31'h0, cflag}, {31'h0, m_c});
    chk($sformatf("zflag a=%0d b=%0d sel=%0d", ia, ib, is), {31'h0, zflag}, {31'h0, m_z});
    chk("out_valid", {31'h0, out_valid}, {31'h0, m_v});
  endtask

  // Directed vector with hand-derived expectations as an independent cross-check.
  task automatic plan(input int ia, input int ib, input int is,
                      input logic [7:0] eo, input logic ec, input logic ez);
    cycle(1'b0, 1'b1, ia, ib, is);
    chk($sformatf("plan_out sel=%0d", is), {24'h0, out}, {24'h0, eo});
    chk($sformatf("plan_c sel=%0d", is), {31'h0, cflag}, {31'h0, ec});
    chk($sformatf("plan_z sel=%0d", is), {31'h0, zflag}, {31'h0, ez});
  endtask

  initial begin
    logic [7:0] held;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0;
    cycle(1'b1, 1'b0, 0, 0, 0);
    cycle(1'b1, 1'b0, 0, 0, 0);

    plan(14, 11, 1, 8'h03, 1'b0, 1'b0);
    plan(14, 11, 2, 8'h9A, 1'b1, 1'b0);
    plan(14, 11, 3, 8'h31, 1'b0, 1'b0);
    plan(14, 11, 4, 8'h00, 1'b0, 1'b1);
    plan(14, 11, 5, 8'h00, 1'b1, 1'b1);
    plan(14, 11, 6, 8'h0A, 1'b0, 1'b0);
    plan(14, 11, 7, 8'h0F, 1'b0, 1'b0);
    plan(14, 11, 0, 8'h19, 1'b1, 1'b0);
    plan(7, 0, 3, 8'h7F, 1'b1, 1'b0);
    plan(5, 5, 1, 8'h00, 1'b0, 1'b1);
    plan(2, 5, 1, 8'h0D, 1'b1, 1'b0);
    plan(11, 2, 4, 8'h2C, 1'b1, 1'b0);
    plan(11, 1, 5, 8'h05, 1'b1, 1'b0);
    plan(8, 3, 5, 8'h01, 1'b0, 1'b0);

    // Hold: idle cycles with changing inputs must not disturb the result.
    held = out;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, i + 3, 15 - i, i + 1);
      chk("hold_out", {24'h0, out}, {24'h0, held});
    end
    // Single request: out_valid pulses for exactly one cycle.
    cycle(1'b0, 1'b1, 9, 6, 0);
    cycle(1'b0, 1'b0, 1, 1, 2);
    chk("pulse_out", {24'h0, out}, {24'h0, 8'h0F});

    // Reset beats a simultaneous request; the next request is captured.
    cycle(1'b1, 1'b1, 15, 15, 2);
    chk("rst_out", {24'h0, out}, 32'h0);
    chk("rst_z", {31'h0, zflag}, 32'h1);
    cycle(1'b0, 1'b1, 3, 4, 2);
    chk("post_rst_out", {24'h0, out}, 32'h0C);

    // Randomized traffic, occasional idle and reset cycles.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
    end
    // Exhaustive sweep of every operand/opcode combination, back to back.
    for (int s = 0; s < 8; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          cycle(1'b0, 1'b1, x, y, s);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
